branch_redirect_queue: RTL
==========================

# branch_redirect_queue

Parametrised successor to the single-entry branch hold logic between execute and fetch. Captures branch/jump resolution records (ALU target, sign-extended offset, PC+2, destination bits, jump flags) from execute and delivers them to fetch. Records are queued in a DEPTH-entry FIFO while fetch is stalled (e.g. I-cache miss), so back-to-back resolutions during a long stall are not lost. Adds configurable edge/level capture, same-cycle push/pop, overflow reporting and flush.

## Interface
- DATA_W, 61, record width: {alu_out[15:0], sign_ext[15:0], pc_2[15:0], dest[10:0], jump_type, jump}
- DEPTH, 4, queue entries; power of two, ≥2
- EDGE_DET, 1, 1 = capture only on rising edge of in_valid; 0 = capture every cycle in_valid=1
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute reports taken branch/jump this cycle
- in_data  in  DATA_W  resolution record from execute
- fetch_stall  in  1  fetch cannot accept a redirect this cycle
- flush  in  1  discard all queued records (pipeline squash)
- out_valid  out  1  redirect presented to fetch and consumed this cycle
- out_data  out  DATA_W  redirect record to fetch
- pending  out  1  queue non-empty
- count  out  $clog2(DEPTH+1)  entries held
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a capture was dropped

## Operation
- Capture: cap = in_valid & ~in_valid_q when EDGE_DET=1 (in_valid_q registered each cycle, reset 0, not cleared by flush); cap = in_valid when EDGE_DET=0.
- pop = ~fetch_stall & pending & ~flush.
- out_valid = ~fetch_stall & ~flush & (pending | cap).
- out_data = head entry when pending, else in_data (bypass). Always driven, also during stall.
- Bypass: empty, ~fetch_stall, cap → record delivered same cycle, not stored.
- Push: cap & ~flush & ~(bypass) & (~full | pop) → write in_data at tail. Strict FIFO order.
- Simultaneous push and pop (pending, not stalled, cap): head delivered, new record written, count unchanged. Legal when full.
- Full, stalled, cap → record dropped, overflow set; queue contents unchanged.
- flush: head/tail pointers and count → 0, overflow → 0; capture in flush cycle discarded; out_valid=0. flush dominates push, pop, overflow.
- Pointers: $clog2(DEPTH) bits, wrap from DEPTH-1 to 0; count tracks occupancy separately (full/empty unambiguous).
- rst dominates flush.

## Timing
- Reset values: out_valid=0, pending=0, count=0, full=0, overflow=0, out_data=in_data (empty bypass path), pointers=0, in_valid_q=0.
- Bypass latency 0 cycles (combinational in→out). Queued record visible on out_data in the cycle after its capture edge.
- Pop takes effect at the clock edge ending the cycle with out_valid=1; next entry presented the following cycle.
- EDGE_DET=1: in_valid held high N cycles yields exactly one capture (first cycle); in_valid high in the cycle rst deasserts counts as a rising edge.
- count/full/pending/overflow registered-derived, update one edge after the event.
- Reset mid-operation: all queued records discarded at that edge; no out_valid in the reset cycle.

## Test plan
- Bypass: empty, fetch_stall=0, in_valid pulse with in_data=61'h0_1234_ABCD_0042_5 → out_valid=1 same cycle, out_data equal, count stays 0.
- Stall queueing: fetch_stall=1, three single-cycle captures (A,B,C) → count=3, out_valid=0; drop stall → A,B,C on out_data on three consecutive cycles with out_valid=1, count 3→2→1→0.
- Overflow (DEPTH=4): stall, five captures → full=1 after 4th, overflow=1 after 5th, 5th record never delivered; flush → count=0, overflow=0.
- Push+pop: 2 queued, fetch_stall=0, capture D each cycle (EDGE_DET=0) → count stays 2, order preserved; wrap pointers past DEPTH-1 with ≥8 records, no corruption.
- Edge mode: EDGE_DET=1, in_valid high 5 cycles during stall → count=1; EDGE_DET=0 same stimulus → count=4, overflow=1.
- Flush/reset collision: flush and cap same cycle → count=0, no out_valid; rst asserted with 3 queued → all outputs at reset values next cycle.

Source files
------------

// File: rtl/branch_redirect_queue.sv
`default_nettype none
// ============================================================================
// Module  : branch_redirect_queue
// Brief   : Buffers branch/jump resolution records from execute for delivery
//           to fetch, with same-cycle bypass, overflow flag and flush.
// Revision: 1.0 - initial release
// ============================================================================
module branch_redirect_queue #(
    parameter int DATA_W   = 61,
    parameter int DEPTH    = 4,
    parameter int EDGE_DET = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       fetch_stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       pending,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic             c_edge    = (EDGE_DET != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_in_valid_q;

    logic w_cap;
    logic w_pending;
    logic w_full;
    logic w_pop;
    logic w_bypass;
    logic w_push;
    logic w_drop;

    // In level mode the delayed in_valid is masked off, so every high cycle captures.
    assign w_cap     = in_valid & ~(c_edge & r_in_valid_q);
    assign w_pending = (r_count != '0);
    assign w_full    = (r_count == c_depth);
    assign w_pop     = ~fetch_stall & w_pending & ~flush;
    assign w_bypass  = ~w_pending & ~fetch_stall & w_cap;
    assign w_push    = w_cap & ~flush & ~w_bypass & (~w_full | w_pop);
    assign w_drop    = w_cap & ~flush & ~w_bypass & w_full & ~w_pop;

    // Reset cycle must never present a redirect, even with stale entries queued.
    assign out_valid = ~rst & ~fetch_stall & ~flush & (w_pending | w_cap);
    assign out_data  = w_pending ? r_mem[r_rd_ptr] : in_data;
    assign pending   = w_pending;
    assign count     = r_count;
    assign full      = w_full;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_in_valid_q <= 1'b0;
        end else begin
            r_in_valid_q <= in_valid;
            if (flush) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_one;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_cnt_one;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule
`default_nettype wire
